// File: rtl/ysyx_23060061_pkg.sv
// Shared types and constants for the IFU/LSU memory arbiter.
package ysyx_23060061_pkg;

  // Arbiter FSM states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } arb_state_e;

  // Master IDs, used for both the grant owner and the round-robin history
  localparam logic MST_IFU = 1'b0;
  localparam logic MST_LSU = 1'b1;

endpackage

// File: rtl/ysyx_23060061_arb_pick.sv
// Combinational 2-way winner select between IFU and LSU.
// YSYX_23060061_ARB_RR_EN defined: round-robin on conflict (grant the master not in last).
// Undefined: fixed priority, LSU wins every conflict.
module ysyx_23060061_arb_pick
  import ysyx_23060061_pkg::*;
(
  input  logic i_ifu_valid,
  input  logic i_lsu_valid,
  input  logic i_last,
  output logic o_gnt_valid,
  output logic o_gnt_id
);

`ifndef YSYX_23060061_ARB_RR_EN
  // History only matters for round-robin
  logic w_unused_last;
  assign w_unused_last = i_last;
`endif

  // Pick a single winner; a lone requester always wins
  always_comb begin
    o_gnt_valid = i_ifu_valid | i_lsu_valid;
    o_gnt_id    = MST_IFU;
    if (i_ifu_valid && i_lsu_valid) begin
`ifdef YSYX_23060061_ARB_RR_EN
      o_gnt_id = ~i_last;
`else
      o_gnt_id = MST_LSU;
`endif
    end else if (i_lsu_valid) begin
      o_gnt_id = MST_LSU;
    end
  end

endmodule

// File: rtl/ysyx_23060061_mem_arbiter.sv
// Two-master (IFU, LSU) to one-slave memory arbiter, one outstanding transaction.
// Winner rule selected by YSYX_23060061_ARB_RR_EN (see ysyx_23060061_arb_pick).
module ysyx_23060061_mem_arbiter
  import ysyx_23060061_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  // IFU
  input  logic                  ifu_valid,
  output logic                  ifu_ready,
  input  logic [ADDR_W-1:0]     ifu_addr,
  output logic                  ifu_rvalid,
  input  logic                  ifu_rready,
  output logic [DATA_W-1:0]     ifu_rdata,
  // LSU
  input  logic                  lsu_valid,
  output logic                  lsu_ready,
  input  logic                  lsu_wen,
  input  logic [ADDR_W-1:0]     lsu_addr,
  input  logic [DATA_W-1:0]     lsu_wdata,
  input  logic [DATA_W/8-1:0]   lsu_wmask,
  output logic                  lsu_rvalid,
  input  logic                  lsu_rready,
  output logic [DATA_W-1:0]     lsu_rdata,
  // Memory slave
  output logic                  mem_valid,
  input  logic                  mem_ready,
  output logic                  mem_wen,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  output logic [DATA_W/8-1:0]   mem_wmask,
  input  logic                  mem_rvalid,
  output logic                  mem_rready,
  input  logic [DATA_W-1:0]     mem_rdata,
  output logic                  busy
);

  arb_state_e          r_state;
  logic                r_gnt;
  logic                r_last;
  logic                r_wen;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [DATA_W/8-1:0] r_wmask;

  logic w_pick_valid;
  logic w_pick_id;
  logic w_accept;
  logic w_own_rready;
  logic w_resp_ifu;
  logic w_resp_lsu;

  ysyx_23060061_arb_pick u_pick (
    .i_ifu_valid (ifu_valid),
    .i_lsu_valid (lsu_valid),
    .i_last      (r_last),
    .o_gnt_valid (w_pick_valid),
    .o_gnt_id    (w_pick_id)
  );

  // Only the winner sees ready, and only while idle
  assign w_accept  = (r_state == IDLE) && w_pick_valid;
  assign ifu_ready = w_accept && (w_pick_id == MST_IFU);
  assign lsu_ready = w_accept && (w_pick_id == MST_LSU);

  assign mem_valid = (r_state == ISSUE);
  assign mem_wen   = r_wen;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign mem_wmask = r_wmask;
  assign busy      = (r_state != IDLE);

  // Response path is a pass-through to the owner; the other master sees nothing
  assign w_resp_ifu   = (r_state == RESP) && (r_gnt == MST_IFU);
  assign w_resp_lsu   = (r_state == RESP) && (r_gnt == MST_LSU);
  assign w_own_rready = (r_gnt == MST_LSU) ? lsu_rready : ifu_rready;
  assign mem_rready   = (r_state == RESP) && w_own_rready;
  assign ifu_rvalid   = w_resp_ifu && mem_rvalid;
  assign lsu_rvalid   = w_resp_lsu && mem_rvalid;
  assign ifu_rdata    = w_resp_ifu ? mem_rdata : '0;
  assign lsu_rdata    = w_resp_lsu ? mem_rdata : '0;

  // Request FSM: accept in IDLE, hold the latched request in ISSUE, route response in RESP
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_gnt   <= MST_IFU;
      r_last  <= MST_IFU;
      r_wen   <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_wmask <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_gnt   <= w_pick_id;
            r_last  <= w_pick_id;
            r_state <= ISSUE;
            if (w_pick_id == MST_LSU) begin
              r_wen   <= lsu_wen;
              r_addr  <= lsu_addr;
              r_wdata <= lsu_wdata;
              r_wmask <= lsu_wmask;
            end else begin
              // Fetches are always plain reads
              r_wen   <= 1'b0;
              r_addr  <= ifu_addr;
              r_wdata <= '0;
              r_wmask <= '0;
            end
          end
        end
        ISSUE: begin
          if (mem_ready) r_state <= RESP;
        end
        RESP: begin
          if (mem_rvalid && w_own_rready) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_23060061_mem_arbiter.sv
// Self-checking bench for ysyx_23060061_mem_arbiter with a scoreboard and a simple slave model.
module tb_ysyx_23060061_mem_arbiter;

  typedef struct packed {
    logic        wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wmask;
  } req_t;

  typedef struct packed {
    logic        mst;
    logic [31:0] data;
  } rsp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        ifu_valid, ifu_ready, ifu_rvalid, ifu_rready;
  logic [31:0] ifu_addr, ifu_rdata;
  logic        lsu_valid, lsu_ready, lsu_wen, lsu_rvalid, lsu_rready;
  logic [31:0] lsu_addr, lsu_wdata, lsu_rdata;
  logic [3:0]  lsu_wmask;
  logic        mem_valid, mem_ready, mem_wen, mem_rvalid, mem_rready;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wmask;
  logic        busy;

  ysyx_23060061_mem_arbiter #(
    .ADDR_W (32),
    .DATA_W (32)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .ifu_valid  (ifu_valid),
    .ifu_ready  (ifu_ready),
    .ifu_addr   (ifu_addr),
    .ifu_rvalid (ifu_rvalid),
    .ifu_rready (ifu_rready),
    .ifu_rdata  (ifu_rdata),
    .lsu_valid  (lsu_valid),
    .lsu_ready  (lsu_ready),
    .lsu_wen    (lsu_wen),
    .lsu_addr   (lsu_addr),
    .lsu_wdata  (lsu_wdata),
    .lsu_wmask  (lsu_wmask),
    .lsu_rvalid (lsu_rvalid),
    .lsu_rready (lsu_rready),
    .lsu_rdata  (lsu_rdata),
    .mem_valid  (mem_valid),
    .mem_ready  (mem_ready),
    .mem_wen    (mem_wen),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_wmask  (mem_wmask),
    .mem_rvalid (mem_rvalid),
    .mem_rready (mem_rready),
    .mem_rdata  (mem_rdata),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Master request queues and scoreboard
  logic [31:0] ifu_q[$];
  req_t        lsu_q[$];
  req_t        exp_req[$];
  rsp_t        exp_rsp[$];

  // Knobs and slave state
  logic        ifu_pulse = 1'b0;
  logic [31:0] pulse_addr = '0;
  int          rdy_stall = 0;
  int          rr_stall = 0;
  logic        rsp_pend = 1'b0;
  logic [31:0] rsp_data = '0;

  // Observation counters
  int   cyc = 0;
  int   ifu_hs = 0, lsu_hs = 0, rsp_cnt = 0, ifu_rsp_cnt = 0;
  int   ifu_acc_cyc = 0, ifu_rsp_cyc = 0;
  int   ifu_rv_cyc = 0;
  int   ready_stall_cyc = 0, rready_stall_cyc = 0;
  int   stable_err = 0, rr_err = 0;
  logic held_v = 1'b0;
  req_t held;

  localparam logic [31:0] WACK = 32'hACC0_0001;

  function automatic logic [31:0] slave_rdata(input logic wen, input logic [31:0] a);
    if (wen) return WACK;
    if (a == 32'h8000_0000) return 32'h0000_0413;
    return a ^ 32'h1357_9BDF;
  endfunction

  function automatic req_t ifu_req(input logic [31:0] a);
    req_t r;
    r.wen = 1'b0; r.addr = a; r.wdata = '0; r.wmask = '0;
    return r;
  endfunction

  // One clock: drive masters/slave at negedge, sample #1 later, score handshakes
  task automatic tick();
    req_t cur, e;
    rsp_t er;
    @(negedge clk);
    ifu_valid = (ifu_q.size() != 0) || ifu_pulse;
    ifu_addr  = (ifu_q.size() != 0) ? ifu_q[0] : pulse_addr;
    if (lsu_q.size() != 0) begin
      lsu_valid = 1'b1;
      lsu_wen   = lsu_q[0].wen;
      lsu_addr  = lsu_q[0].addr;
      lsu_wdata = lsu_q[0].wdata;
      lsu_wmask = lsu_q[0].wmask;
    end else begin
      lsu_valid = 1'b0; lsu_wen = 1'b0; lsu_addr = '0; lsu_wdata = '0; lsu_wmask = '0;
    end
    mem_ready  = (rdy_stall == 0);
    mem_rvalid = rsp_pend;
    mem_rdata  = rsp_pend ? rsp_data : '0;
    ifu_rready = (rr_stall == 0);
    lsu_rready = (rr_stall == 0);
    #1;
    if (ifu_valid && ifu_ready) begin
      ifu_hs++;
      ifu_acc_cyc = cyc;
      if (ifu_q.size() != 0) void'(ifu_q.pop_front());
    end
    if (lsu_valid && lsu_ready) begin
      lsu_hs++;
      void'(lsu_q.pop_front());
    end
    cur.wen = mem_wen; cur.addr = mem_addr; cur.wdata = mem_wdata; cur.wmask = mem_wmask;
    if (mem_valid) begin
      if (held_v && cur !== held) stable_err++;
      held   = cur;
      held_v = 1'b1;
      if (!mem_ready) ready_stall_cyc++;
    end else begin
      held_v = 1'b0;
    end
    if (mem_valid && mem_ready) begin
      n_cmp++;
      if (exp_req.size() == 0) begin
        n_err++;
        $display("FAIL mem_req_unexpected: got addr=%h wen=%b, expected no request", mem_addr,
                 mem_wen);
      end else begin
        e = exp_req.pop_front();
        if (!cur.wen) cur.wdata = '0;
        if (!e.wen) e.wdata = '0;
        if (cur !== e) begin
          n_err++;
          $display("FAIL mem_req: got wen=%b addr=%h wdata=%h wmask=%h, expected %b %h %h %h",
                   cur.wen, cur.addr, cur.wdata, cur.wmask, e.wen, e.addr, e.wdata, e.wmask);
        end
      end
      rsp_pend = 1'b1;
      rsp_data = slave_rdata(mem_wen, mem_addr);
      held_v   = 1'b0;
    end else if (mem_rvalid && mem_rready) begin
      rsp_pend = 1'b0;
    end
    if (mem_valid && rdy_stall > 0) rdy_stall--;
    if (ifu_rvalid) ifu_rv_cyc++;
    if ((ifu_rvalid && !ifu_rready) || (lsu_rvalid && !lsu_rready)) begin
      rready_stall_cyc++;
      if (mem_rready) rr_err++;
    end
    if ((ifu_rvalid || lsu_rvalid) && rr_stall > 0) rr_stall--;
    if ((ifu_rvalid && ifu_rready) || (lsu_rvalid && lsu_rready)) begin
      rsp_cnt++;
      if (ifu_rvalid) begin
        ifu_rsp_cnt++;
        ifu_rsp_cyc = cyc;
      end
      n_cmp++;
      if (exp_rsp.size() == 0) begin
        n_err++;
        $display("FAIL rsp_unexpected: got ifu_rvalid=%b lsu_rvalid=%b, expected none",
                 ifu_rvalid, lsu_rvalid);
      end else begin
        er = exp_rsp.pop_front();
        if (ifu_rvalid !== (er.mst == 1'b0) || lsu_rvalid !== (er.mst == 1'b1) ||
            (er.mst ? lsu_rdata : ifu_rdata) !== er.data) begin
          n_err++;
          $display("FAIL rsp: got ifu_rv=%b lsu_rv=%b ifu_rdata=%h lsu_rdata=%h, expected mst=%0d data=%h",
                   ifu_rvalid, lsu_rvalid, ifu_rdata, lsu_rdata, er.mst, er.data);
        end
      end
    end
    ifu_pulse = 1'b0;
    cyc++;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n = 0;
    while ((exp_rsp.size() != 0 || busy || ifu_q.size() != 0 || lsu_q.size() != 0) &&
           n < budget) begin
      tick();
      n++;
    end
    n_cmp++;
    if (n >= budget) begin
      n_err++;
      $display("FAIL %s_timeout: got %0d pending responses after %0d cycles, expected 0",
               name, exp_rsp.size(), budget);
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #1;
    rsp_pend = 1'b0; rdy_stall = 0; rr_stall = 0; held_v = 1'b0;
    ifu_q.delete(); lsu_q.delete(); exp_req.delete(); exp_rsp.delete();
    tick();
    tick();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    ifu_valid = 1'b0; ifu_addr = '0; ifu_rready = 1'b0;
    lsu_valid = 1'b0; lsu_wen = 1'b0; lsu_addr = '0; lsu_wdata = '0; lsu_wmask = '0;
    lsu_rready = 1'b0; mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    tick();
    tick();
    n_cmp++;
    if ({busy, mem_valid, mem_rready, ifu_ready, lsu_ready, ifu_rvalid, lsu_rvalid} !== 7'b0) begin
      n_err++;
      $display("FAIL reset_handshake: got busy/mv/mrr/ir/lr/irv/lrv=%b, expected 0000000",
               {busy, mem_valid, mem_rready, ifu_ready, lsu_ready, ifu_rvalid, lsu_rvalid});
    end
    n_cmp++;
    if ({mem_wen, mem_addr, mem_wdata, mem_wmask, ifu_rdata, lsu_rdata} !== '0) begin
      n_err++;
      $display("FAIL reset_data: got wen=%b addr=%h wdata=%h wmask=%h ir=%h lr=%h, expected 0",
               mem_wen, mem_addr, mem_wdata, mem_wmask, ifu_rdata, lsu_rdata);
    end
    rst = 1'b1;
  endtask

  task automatic test_ifu_alone();
    rsp_t r;
    ifu_q.push_back(32'h8000_0000);
    exp_req.push_back(ifu_req(32'h8000_0000));
    r.mst = 1'b0; r.data = 32'h0000_0413;
    exp_rsp.push_back(r);
    wait_idle("ifu_alone", 20);
    n_cmp++;
    if (ifu_rsp_cyc - ifu_acc_cyc !== 2) begin
      n_err++;
      $display("FAIL ifu_latency: got %0d cycles accept-to-response, expected 2",
               ifu_rsp_cyc - ifu_acc_cyc);
    end
  endtask

  task automatic test_lsu_write();
    req_t q;
    rsp_t r;
    int   rv0 = ifu_rv_cyc;
    q.wen = 1'b1; q.addr = 32'h8000_1000; q.wdata = 32'hDEAD_BEEF; q.wmask = 4'hF;
    lsu_q.push_back(q);
    exp_req.push_back(q);
    r.mst = 1'b1; r.data = WACK;
    exp_rsp.push_back(r);
    wait_idle("lsu_write", 20);
    n_cmp++;
    if (ifu_rv_cyc - rv0 !== 0) begin
      n_err++;
      $display("FAIL lsu_write_ifu_rvalid: got %0d cycles of ifu_rvalid, expected 0",
               ifu_rv_cyc - rv0);
    end
  endtask

  task automatic test_conflict();
    logic [31:0] ia[3];
    req_t        la[3];
    rsp_t        r;
    int          ihs0, lhs0;
    do_reset();
    ihs0 = ifu_hs;
    lhs0 = lsu_hs;
    for (int i = 0; i < 3; i++) begin
      ia[i] = 32'h8000_0100 + 32'(4 * i);
      la[i].wen = 1'b0; la[i].addr = 32'h8000_2000 + 32'(16 * i);
      la[i].wdata = '0; la[i].wmask = '0;
      ifu_q.push_back(ia[i]);
      lsu_q.push_back(la[i]);
    end
`ifdef YSYX_23060061_ARB_RR_EN
    // Alternation starting with LSU since history resets to IFU
    for (int i = 0; i < 3; i++) begin
      exp_req.push_back(la[i]);
      r.mst = 1'b1; r.data = slave_rdata(1'b0, la[i].addr); exp_rsp.push_back(r);
      exp_req.push_back(ifu_req(ia[i]));
      r.mst = 1'b0; r.data = slave_rdata(1'b0, ia[i]); exp_rsp.push_back(r);
    end
`else
    // LSU keeps winning while it holds valid
    for (int i = 0; i < 3; i++) begin
      exp_req.push_back(la[i]);
      r.mst = 1'b1; r.data = slave_rdata(1'b0, la[i].addr); exp_rsp.push_back(r);
    end
    for (int i = 0; i < 3; i++) begin
      exp_req.push_back(ifu_req(ia[i]));
      r.mst = 1'b0; r.data = slave_rdata(1'b0, ia[i]); exp_rsp.push_back(r);
    end
`endif
    wait_idle("conflict", 100);
    n_cmp++;
    if (ifu_hs - ihs0 !== 3 || lsu_hs - lhs0 !== 3) begin
      n_err++;
      $display("FAIL conflict_grants: got ifu=%0d lsu=%0d, expected 3 and 3",
               ifu_hs - ihs0, lsu_hs - lhs0);
    end
  endtask

  task automatic test_stall();
    rsp_t r;
    int   rc0 = rsp_cnt;
    ready_stall_cyc = 0; rready_stall_cyc = 0; stable_err = 0; rr_err = 0;
    rdy_stall = 5;
    rr_stall = 4;
    ifu_q.push_back(32'h8000_0200);
    exp_req.push_back(ifu_req(32'h8000_0200));
    r.mst = 1'b0; r.data = slave_rdata(1'b0, 32'h8000_0200);
    exp_rsp.push_back(r);
    wait_idle("stall", 40);
    n_cmp++;
    if (ready_stall_cyc !== 5) begin
      n_err++;
      $display("FAIL stall_issue_cycles: got %0d, expected 5", ready_stall_cyc);
    end
    n_cmp++;
    if (rready_stall_cyc !== 4) begin
      n_err++;
      $display("FAIL stall_resp_cycles: got %0d, expected 4", rready_stall_cyc);
    end
    n_cmp++;
    if (stable_err !== 0 || rr_err !== 0) begin
      n_err++;
      $display("FAIL stall_hold: got field changes=%0d mem_rready-while-stalled=%0d, expected 0 0",
               stable_err, rr_err);
    end
    n_cmp++;
    if (rsp_cnt - rc0 !== 1) begin
      n_err++;
      $display("FAIL stall_single_rsp: got %0d responses, expected 1", rsp_cnt - rc0);
    end
  endtask

  task automatic test_reset_mid();
    rsp_t r;
    int   n = 0;
    int   rc0;
    rr_stall = 50;
    ifu_q.push_back(32'h8000_0300);
    exp_req.push_back(ifu_req(32'h8000_0300));
    r.mst = 1'b0; r.data = slave_rdata(1'b0, 32'h8000_0300);
    exp_rsp.push_back(r);
    while (!ifu_rvalid && n < 10) begin
      tick();
      n++;
    end
    n_cmp++;
    if (ifu_rvalid !== 1'b1) begin
      n_err++;
      $display("FAIL reset_mid_reach_resp: got ifu_rvalid=%b, expected 1", ifu_rvalid);
    end
    #2;
    rst = 1'b0;
    #1;
    n_cmp++;
    if ({busy, mem_valid, mem_rready, ifu_ready, lsu_ready, ifu_rvalid, lsu_rvalid} !== 7'b0) begin
      n_err++;
      $display("FAIL reset_mid_outputs: got busy/mv/mrr/ir/lr/irv/lrv=%b, expected 0000000",
               {busy, mem_valid, mem_rready, ifu_ready, lsu_ready, ifu_rvalid, lsu_rvalid});
    end
    n_cmp++;
    if (mem_addr !== 32'h0) begin
      n_err++;
      $display("FAIL reset_mid_req_reg: got mem_addr=%h, expected 0", mem_addr);
    end
    exp_rsp.delete();
    rsp_pend = 1'b0; rr_stall = 0; held_v = 1'b0;
    tick();
    rst = 1'b1;
    rc0 = rsp_cnt;
    ifu_q.push_back(32'h8000_0304);
    exp_req.push_back(ifu_req(32'h8000_0304));
    r.mst = 1'b0; r.data = slave_rdata(1'b0, 32'h8000_0304);
    exp_rsp.push_back(r);
    wait_idle("reset_mid_after", 20);
    n_cmp++;
    if (rsp_cnt - rc0 !== 1) begin
      n_err++;
      $display("FAIL reset_mid_after_rsp: got %0d responses, expected 1", rsp_cnt - rc0);
    end
  endtask

  task automatic test_ifu_pulse();
    req_t q;
    rsp_t r;
    int   ihs0 = ifu_hs;
    int   irc0 = ifu_rsp_cnt;
    rdy_stall = 3;
    q.wen = 1'b0; q.addr = 32'h8000_3000; q.wdata = '0; q.wmask = '0;
    lsu_q.push_back(q);
    exp_req.push_back(q);
    r.mst = 1'b1; r.data = slave_rdata(1'b0, q.addr);
    exp_rsp.push_back(r);
    tick();
    pulse_addr = 32'h8000_0400;
    ifu_pulse  = 1'b1;
    tick();
    wait_idle("ifu_pulse", 20);
    n_cmp++;
    if (ifu_hs - ihs0 !== 0 || ifu_rsp_cnt - irc0 !== 0) begin
      n_err++;
      $display("FAIL ifu_pulse_spurious: got ifu grants=%0d responses=%0d, expected 0 0",
               ifu_hs - ihs0, ifu_rsp_cnt - irc0);
    end
  endtask

  initial begin
    test_reset();
    test_ifu_alone();
    test_lsu_write();
    test_stall();
    test_ifu_pulse();
    test_reset_mid();
    test_conflict();
    n_cmp++;
    if (exp_req.size() !== 0 || exp_rsp.size() !== 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: got %0d req / %0d rsp left, expected 0 0",
               exp_req.size(), exp_rsp.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ysyx_23060061_mem_arbiter.md
# ysyx_23060061_mem_arbiter

Two-master, one-slave memory arbiter that shares the single physical memory port (the SRAM/DPI `paddr_read`/`paddr_write` path) between the IFU instruction fetch and the LSU load/store unit. It sits between the fetch/execute units and the memory model. It accepts one request at a time with valid/ready handshakes, forwards it to the slave, and routes the response back to the originating master. Winner selection on conflict is fixed-priority or round-robin, chosen at compile time.

## Interface
Parameters:
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width; `DATA_W/8` mask bits

Ports:
- `clk`  in  1  clock; all logic on rising edge
- `rst`  in  1  asynchronous, active-low reset
- `ifu_valid` / `ifu_ready`  in / out  1  IFU read request handshake
- `ifu_addr`  in  ADDR_W  IFU fetch address
- `ifu_rvalid` / `ifu_rready`  out / in  1  IFU response handshake
- `ifu_rdata`  out  DATA_W  fetched instruction
- `lsu_valid` / `lsu_ready`  in / out  1  LSU request handshake
- `lsu_wen`  in  1  1 = write, 0 = read
- `lsu_addr`  in  ADDR_W  LSU address
- `lsu_wdata`  in  DATA_W  write data
- `lsu_wmask`  in  DATA_W/8  byte write mask
- `lsu_rvalid` / `lsu_rready`  out / in  1  LSU response handshake (read data or write ack)
- `lsu_rdata`  out  DATA_W  load data
- `mem_valid` / `mem_ready`  out / in  1  slave request handshake
- `mem_wen`, `mem_addr`, `mem_wdata`, `mem_wmask`  out  1 / ADDR_W / DATA_W / DATA_W/8  latched request fields
- `mem_rvalid` / `mem_rready`  in / out  1  slave response handshake
- `mem_rdata`  in  DATA_W  slave response data
- `busy`  out  1  high in any state other than IDLE

## Operation
- FSM states: IDLE, ISSUE, RESP. Owner register `gnt` (0 = IFU, 1 = LSU).
- IDLE: winner = one valid master, or the pick rule if both are valid. Winner's `*_ready` = 1 combinationally; loser's `*_ready` = 0. On handshake: latch the fields into the request register, set `gnt`, go to ISSUE. IFU requests latch `wen = 0` and `wmask = 0`.
- ISSUE: `mem_valid` = 1 with latched fields held stable. On `mem_valid & mem_ready`, go to RESP.
- RESP: `mem_rready` = rready of `gnt` master. That master's `*_rvalid` = `mem_rvalid`, and its `*_rdata` = `mem_rdata` (combinational pass-through). On `mem_rvalid & mem_rready`, go to IDLE.
- Non-owner `*_rvalid` is always 0. `mem_rvalid` is ignored outside RESP.
- Pick rule: fixed, or round-robin (see Configuration). `last` register updates on every accepted request.
- A master deasserting valid in IDLE before a handshake is legal. Nothing is latched and no grant is made.

## Timing
- Reset values: state = IDLE, `gnt` = 0, `last` = 0 (IFU). All `*_ready`, `*_rvalid`, `mem_valid`, `mem_rready` and `busy` = 0. Request register and data outputs = 0.
- Reset mid-operation returns the FSM asynchronously to IDLE. The in-flight request is dropped, with no response delivered.
- Request accept in cycle N puts `mem_valid` high in cycle N+1.
- Best-case occupancy is 3 cycles: accept, issue with `mem_ready` = 1, response with `mem_rvalid` = `*_rready` = 1.
- Back-to-back: in the cycle after the RESP handshake, the FSM is in IDLE and can accept again. Maximum throughput is 1 request per 3 cycles.
- Stalls: `mem_ready` = 0 holds ISSUE indefinitely. Master `*_rready` = 0 holds RESP, with `mem_rready` = 0 back-pressuring the slave.
- Only one outstanding transaction, so there is no reordering.

## Configuration
- Macro `YSYX_23060061_ARB_RR_EN`.
- Defined: round-robin. On conflict, the grant goes to the master not in `last`. Since `last` resets to IFU, the first conflict goes to LSU.
- Undefined: fixed priority. LSU always wins a conflict; `last` is still maintained but unused.

## Structure
- Shared package `ysyx_23060061_pkg`:
  - FSM state enum (IDLE, ISSUE, RESP)
  - master-ID constants `MST_IFU` = 0, `MST_LSU` = 1
- Sub-module `ysyx_23060061_arb_pick`: combinational 2-way winner select.
  - Inputs: two valids, `last`.
  - Output: grant ID and grant-valid.
  - Contains the macro-dependent rule.

## Test plan
- IFU alone: `ifu_addr` = 0x80000000, slave returns 0x00000413 with 0-cycle stalls → `ifu_rvalid` with `ifu_rdata` = 0x00000413 in the 3rd cycle. `mem_wen` = 0, `mem_wmask` = 0.
- LSU write: addr 0x80001000, wdata 0xDEADBEEF, wmask 0xF → `mem_*` fields match exactly, then `lsu_rvalid` ack. `ifu_rvalid` stays 0 throughout.
- Simultaneous IFU+LSU valid, three times in a row:
  - RR build: grants LSU, IFU, LSU.
  - Fixed build: grants LSU, LSU, LSU, with IFU served only after LSU drops valid.
- Stalls: `mem_ready` low for 5 cycles, then `ifu_rready` low for 4 cycles → `mem_*` fields stable throughout, `mem_rready` = 0 during the rready stall, single response delivered.
- Reset asserted in RESP → all handshake outputs 0 immediately, state IDLE, `busy` = 0. A subsequent request completes normally.
- IFU valid pulses 1 cycle while LSU holds the grant → no spurious IFU grant or response.
